muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have a single clock and a reset that is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 flush  input  1  synchronous abort of an in-flight operation (pipeline kill).
REQ-006 op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 a  input  32  operand rs1 (multiplicand / dividend).
REQ-008 b  input  32  operand rs2 (multiplier / divisor).
REQ-009 busy  output  1  high while an operation is in progress (CALC or DONE state).
REQ-010 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-011 result  output  32  final value; feeds the execute-stage writeback mux beside the ALU result.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE; the reset state is IDLE.
REQ-013 In IDLE with start=1 at edge k, the block SHALL latch op, a and b, clear the iteration counter, and enter CALC.
REQ-014 CALC SHALL last exactly 32 cycles (one radix-2 iteration per cycle, 5-bit counter 0..31); after the 32nd iteration the FSM SHALL enter DONE.
REQ-015 done SHALL be high only in DONE, for exactly one cycle, at fixed latency: the 33rd edge after edge k; the FSM then returns to IDLE.
REQ-016 Latency SHALL be identical for all eight ops, including special cases.
REQ-017 result SHALL be updated on entry to DONE and SHALL hold that value until the next DONE or reset.
REQ-018 start asserted while busy=1 SHALL be ignored; a start in the same cycle as done (state DONE) SHALL also be ignored.
REQ-019 Multiply SHALL use shift-add on 32-bit operand magnitudes with a 64-bit product, followed by a conditional two's-complement negate.
REQ-020 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-021 Signedness: MULH treats a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
REQ-022 Divide SHALL use restoring shift-subtract on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); DIVU and REMU are unsigned.
REQ-023 Divide by zero: DIV and DIVU SHALL return 0xFFFFFFFF; REM and REMU SHALL return a.
REQ-024 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-025 flush=1 in CALC or DONE SHALL return the FSM to IDLE on the next edge with done=0; result is unchanged; flush has priority over the done transition.
REQ-026 flush=1 together with start=1 in IDLE SHALL start nothing.
REQ-027 Changes on a, b or op after acceptance SHALL have no effect on the in-flight operation.

Reset
REQ-028 On rst=1, the block SHALL immediately (without waiting for a clock edge) set state IDLE, busy=0, done=0, result=0x00000000, counter=0, and clear the internal operand/accumulator registers to 0.
REQ-029 Reset asserted mid-CALC SHALL abort the operation; no done pulse is produced after release.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 MUL with a=7, b=0xFFFFFFFD -> done exactly 33 edges after start, result=0xFFFFFFEB; MULH with a=b=0x80000000 -> 0x40000000; MULHU with a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV with a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU with a=100, b=7 -> 14; REMU with the same operands -> 2.
REQ-033 DIVU with a=5, b=0 -> 0xFFFFFFFF; REMU with a=5, b=0 -> 5; DIV with a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; latency for each is still 33.
REQ-034 Assert rst asynchronously on the 10th CALC cycle -> busy=0, done=0 and result=0 immediately; no done pulse within 40 cycles after release.
REQ-035 Pulse start again on CALC cycle 5 with different operands -> the second request is ignored and the first result is returned; flush on CALC cycle 20 -> busy=0 on the next edge, no done pulse, result holds its prior value.
REQ-036 Issue back-to-back requests (start on the cycle after done) -> each completes with correct result and 33-edge latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add / restoring divide on magnitudes.
// Fixed 33-edge start-to-done latency for every op; start is ignored while busy.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [2:0]  op_q;
   logic [31:0] a_q;
   logic        bz_q;
   logic        neg_q;
   logic [31:0] mag_d;
   logic [63:0] acc;

   logic        accept;
   logic        sa, sb, neg_in;
   logic [31:0] abs_a, abs_b;
   logic [32:0] mul_sum, rem_sh, rem_new;
   logic        div_ge;
   logic [63:0] acc_nxt, fix64;
   logic [31:0] quo_fix, rem_fix, fin;

   assign accept = (state == IDLE) && start && !flush;

   always_comb begin
      sa     = a[31] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
      sb     = b[31] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
      abs_a  = sa ? (~a + 32'd1) : a;
      abs_b  = sb ? (~b + 32'd1) : b;
      // Remainder takes the dividend's sign; everything else is sign(a) ^ sign(b).
      neg_in = (op == OP_REM) ? sa : (sa ^ sb);
   end

   // Multiply: acc = {partial, multiplier}; shift right, adding multiplicand on lsb.
   // Divide:   acc = {remainder, dividend/quotient}; shift left, subtract if it fits.
   always_comb begin
      mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_d} : 33'd0);
      rem_sh  = {acc[63:32], acc[31]};
      div_ge  = rem_sh >= {1'b0, mag_d};
      rem_new = div_ge ? (rem_sh - {1'b0, mag_d}) : rem_sh;
      acc_nxt = op_q[2] ? {rem_new[31:0], acc[30:0], div_ge} : {mul_sum, acc[31:1]};
   end

   always_comb begin
      fix64   = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;
      quo_fix = neg_q ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
      rem_fix = neg_q ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];
      fin     = 32'd0;
      case (op_q)
         OP_MUL:            fin = fix64[31:0];
         3'd1, 3'd2, 3'd3:  fin = fix64[63:32];
         3'd4, 3'd5:        fin = bz_q ? 32'hFFFF_FFFF : quo_fix;
         default:           fin = bz_q ? a_q : rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = CALC;
         CALC: begin
            if (flush)              state_nxt = IDLE;
            else if (cnt == 5'd31)  state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE) && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= 5'd0;
         op_q   <= 3'd0;
         a_q    <= 32'd0;
         bz_q   <= 1'b0;
         neg_q  <= 1'b0;
         mag_d  <= 32'd0;
         acc    <= 64'd0;
         result <= 32'd0;
      end else if (accept) begin
         cnt   <= 5'd0;
         op_q  <= op;
         a_q   <= a;
         bz_q  <= (b == 32'd0);
         neg_q <= neg_in;
         mag_d <= op[2] ? abs_b : abs_a;
         acc   <= {32'd0, (op[2] ? abs_a : abs_b)};
      end else if (state == CALC && !flush) begin
         acc <= acc_nxt;
         cnt <= cnt + 5'd1;
         if (cnt == 5'd31) result <= fin;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, decoupled done monitor.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done;
   logic [31:0] result;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          edge_s;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   int   done_cnt = 0;

   always @(posedge clk) edge_cnt = edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %h expected no done", result);
         end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("latency", 32'(edge_cnt + 1 - e.edge_s), 32'd33);
         end
      end
   end

   task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp, input bit push, input bit rel);
      exp_t e;
      @(negedge clk);
      if (rel) rst = 1'b0;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble inputs after acceptance; the in-flight op must not see them.
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      if (push) begin
         e.res = exp;
         e.edge_s = edge_cnt;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      end
   endtask

   localparam int NV = 14;
   logic [2:0]  v_op  [NV] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
   logic [31:0] v_a   [NV] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFFB, 32'hFFFF_FFFB};
   logic [31:0] v_b   [NV] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
   logic [31:0] v_exp [NV] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFB};

   initial begin
      int dc;
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);

      // First request issued on the very edge after reset release, then back-to-back.
      start_op(v_op[0], v_a[0], v_b[0], v_exp[0], 1'b1, 1'b1);
      wait_done();
      for (int i = 1; i < NV; i++) begin
         start_op(v_op[i], v_a[i], v_b[i], v_exp[i], 1'b1, 1'b0);
         wait_done();
      end

      // Start during the DONE cycle must not launch anything.
      start_op(3'd0, 32'd3, 32'd5, 32'd15, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_in_done_busy", {31'd0, busy}, 32'd0);

      // Flush mid-CALC: no done, result keeps the previous value.
      start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_result", result, 32'd15);
      dc = done_cnt;
      repeat (40) @(negedge clk);
      check("flush_no_done", 32'(done_cnt), 32'(dc));

      @(negedge clk);
      start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      check("flush_start_idle", {31'd0, busy}, 32'd0);

      // Asynchronous reset on the 10th CALC cycle.
      start_op(3'd0, 32'd9, 32'd9, 32'd81, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_result", result, 32'd0);
      dc = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("arst_no_done", 32'(done_cnt), 32'(dc));

      start_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, 1'b0);
      wait_done();
      start_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 1'b0);
      wait_done();

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
